instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch stage directly upstream of the instruction decoder. Reads 8-bit instructions from program memory at the program counter and latches each one into an instruction register. It presents each instruction to the decoder for exactly the number of cycles its opcode class needs. Between instructions it drives a bubble, so the decoder's per-instruction counters restart cleanly.

Parameters:
PC_W, 8, program counter and program-memory address width
RESET_PC, 0, PC value loaded on reset
HOLD_LDROM, 4, issue cycles for opcode 3'b001 (RAM->ROM->GPR load)
HOLD_RMOV, 2, issue cycles for opcode 3'b010 (RAM->GPR move)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  freezes the issue hold counter and the fetch request
pmem_rd_en  out  1  program-memory read strobe, one cycle per fetch
pmem_addr  out  PC_W  program-memory address (= pc)
pmem_data  in  8  program-memory read data
pmem_valid  in  1  pmem_data valid; at least 1 cycle after pmem_rd_en
instruction  out  8  to decoder; BUBBLE when not issuing
instr_valid  out  1  high while instruction holds a real opcode
pc  out  PC_W  address of the next instruction to fetch
halted  out  1  high once HALT has issued

Behaviour:
- Reset (rst=1 at a clk edge, any state, mid-operation included):
  - state=FETCH, pc=RESET_PC, instruction=BUBBLE (8'h80).
  - instr_valid=0, pmem_rd_en=0, halted=0, hold counter=0.
  - Outstanding memory data is discarded.
- FETCH:
  - stall=0: pmem_rd_en=1 for one cycle with pmem_addr=pc, then go to WAIT.
  - stall=1: stay in FETCH with pmem_rd_en=0.
- WAIT:
  - pmem_rd_en=0. Wait for pmem_valid=1.
  - On that edge: IR<=pmem_data; pc<=pc+1 (modulo 2^PC_W, so 255->0 wraps); load hold count from the opcode; go to ISSUE.
  - pmem_valid in any state other than WAIT is ignored.
- Hold count by IR[7:5]:
  - 001 -> HOLD_LDROM
  - 010 -> HOLD_RMOV
  - 111 -> 1 (HALT)
  - all others -> 1
- ISSUE:
  - instruction=IR, instr_valid=1, stable for the whole hold.
  - Counter decrements on each non-stalled cycle; stall=1 holds both the counter and the outputs.
  - When the counter reaches 1 on a non-stalled cycle: HALT opcode (3'b111) -> go to HALTED; otherwise go to FETCH.
  - A bubble is therefore always driven for at least 2 cycles between consecutive instructions (FETCH plus WAIT).
- HALTED:
  - instruction=BUBBLE, instr_valid=0, halted=1.
  - pmem_rd_en stays 0. Exit only by rst.
- All outputs are registered; no combinational path from inputs to outputs.
- Minimum throughput: 2 + hold cycles per instruction with single-cycle memory.

Optional Feature:
FETCH_JUMP_EN
- Defined: opcode 3'b110 is an absolute jump.
  - In WAIT, on pmem_valid: pc<={ {(PC_W-5){1'b0}}, pmem_data[4:0] } instead of pc+1.
  - The jump is still issued for 1 cycle with instr_valid=1 (the decoder treats it as its default case).
- Undefined: 3'b110 is an ordinary 1-cycle instruction and pc increments normally.

Decomposition:
- Shared package fetch_pkg:
  - Opcode localparams OP_STORE=3'b000, OP_LDROM=3'b001, OP_RMOV=3'b010, OP_ALU=3'b011, OP_JMP=3'b110, OP_HALT=3'b111.
  - BUBBLE=8'h80.
  - State enum fetch_state_t {FETCH, WAIT, ISSUE, HALTED}.
- One natural sub-module, issue_hold_cnt: opcode-to-hold-count lookup plus a loadable down-counter with stall, exposing a done flag.

Test Plan:
- Reset then memory {8'h01, 8'h22}, 1-cycle latency:
  - pmem_addr=0 then 1.
  - 8'h01 issued for 1 cycle; 8'h22 (LDROM) issued for exactly 4 cycles.
  - 8'h80 with instr_valid=0 in all gaps.
- RMOV 8'h45 with stall=1 on its 2nd issue cycle -> instruction held for 3 cycles total; pc unchanged during the stall.
- pc=255 fetch of 8'h00 -> pc wraps to 0; next pmem_addr=0.
- Memory latency 3 cycles plus a spurious pmem_valid pulse while in ISSUE -> pulse ignored; IR captured only from the valid in WAIT.
- 8'hE0 (HALT) -> issued for 1 cycle, then halted=1, pmem_rd_en stays 0 for 20 cycles; rst=1 mid-halt -> pc=0 and a fetch restarts.
- FETCH_JUMP_EN defined, 8'hD5 at pc=3 -> next pmem_addr=8'h15. Undefined -> next pmem_addr=4.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcode classes, the bubble
// encoding, the fetch FSM states and the opcode-to-hold-count lookup.
package fetch_pkg;

    localparam logic [2:0] OP_STORE = 3'b000;
    localparam logic [2:0] OP_LDROM = 3'b001;
    localparam logic [2:0] OP_RMOV  = 3'b010;
    localparam logic [2:0] OP_ALU   = 3'b011;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [7:0] BUBBLE = 8'h80;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        ISSUE,
        HALTED
    } fetch_state_t;

    // Number of cycles the decoder needs to see an instruction of a given class.
    function automatic logic [CNT_W-1:0] hold_for_opcode(input logic [2:0] opcode,
                                                         input int         ldrom,
                                                         input int         rmov);
        case (opcode)
            OP_LDROM:                         hold_for_opcode = CNT_W'(ldrom);
            OP_RMOV:                          hold_for_opcode = CNT_W'(rmov);
            OP_STORE, OP_ALU, OP_JMP, OP_HALT: hold_for_opcode = CNT_W'(1);
            default:                          hold_for_opcode = CNT_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_issue_hold_cnt.sv
// Issue hold counter: loads the hold length for a freshly captured opcode and
// counts it down on non-stalled issue cycles; done marks the final issue cycle.
module issue_hold_cnt
    import fetch_pkg::*;
#(
    parameter int HOLD_LDROM = 4,
    parameter int HOLD_RMOV  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [2:0] opcode_i,
    input  logic       en_i,
    input  logic       stall_i,
    output logic       done_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = hold_for_opcode(opcode_i, HOLD_LDROM, HOLD_RMOV);
        end else if (en_i && !stall_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == ONE);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage feeding the decoder: fetch, wait for memory, issue for the opcode's
// hold length, bubble in between. Define FETCH_JUMP_EN to make opcode 3'b110 an absolute jump.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int RESET_PC   = 0,
    parameter int HOLD_LDROM = 4,
    parameter int HOLD_RMOV  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic            pmem_rd_en,
    output logic [PC_W-1:0] pmem_addr,
    input  logic [7:0]      pmem_data,
    input  logic            pmem_valid,
    output logic [7:0]      instruction,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] next_pc;
    logic [7:0]      ir_q, ir_d;
    logic [7:0]      instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            rd_en_q, rd_en_d;
    logic            halted_q, halted_d;
    logic            capture;
    logic            hold_done;

    assign capture = (state_q == WAIT) && pmem_valid;

    issue_hold_cnt #(
        .HOLD_LDROM (HOLD_LDROM),
        .HOLD_RMOV  (HOLD_RMOV)
    ) u_hold (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (capture),
        .opcode_i (pmem_data[7:5]),
        .en_i     (state_q == ISSUE),
        .stall_i  (stall),
        .done_o   (hold_done)
    );

`ifdef FETCH_JUMP_EN
    assign next_pc = (pmem_data[7:5] == OP_JMP) ? PC_W'(pmem_data[4:0])
                                                : pc_q + PC_W'(1);
`else
    assign next_pc = pc_q + PC_W'(1);
`endif

    // The read strobe is registered, so the request for a FETCH cycle is decided
    // on the edge entering it; a stall only suppresses requests not yet launched.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            FETCH: begin
                if (rd_en_q) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (pmem_valid) begin
                    ir_d    = pmem_data;
                    pc_d    = next_pc;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall && hold_done) begin
                    state_d = (ir_q[7:5] == OP_HALT) ? HALTED : FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        rd_en_d  = (state_d == FETCH) && !stall;
        valid_d  = (state_d == ISSUE);
        instr_d  = valid_d ? ir_d : BUBBLE;
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= PC_W'(RESET_PC);
            ir_q     <= BUBBLE;
            instr_q  <= BUBBLE;
            valid_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            rd_en_q  <= rd_en_d;
            halted_q <= halted_d;
        end
    end

    assign pmem_rd_en  = rd_en_q;
    assign pmem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a latency-programmable memory model, a monitor
// that logs issued instructions and fetch addresses, and per-scenario scoreboard tasks.
module tb_instr_fetch;

    typedef struct {
        logic [7:0] instr;
        int         cycles;
    } issue_t;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       pmem_rd_en;
    logic [7:0] pmem_addr;
    logic [7:0] pmem_data;
    logic       pmem_valid;
    logic [7:0] instruction;
    logic       instr_valid;
    logic [7:0] pc;
    logic       halted;

    int tests;
    int failed;

    logic [7:0] mem [256];
    int         lat;
    bit         spur_arm;

    issue_t     exp_q[$];
    issue_t     obs_q[$];
    logic [7:0] exp_addr_q[$];
    logic [7:0] obs_addr_q[$];

    int         bubble_err;
    int         rd_long_err;
    int         min_gap;

    instr_fetch #(
        .PC_W       (8),
        .RESET_PC   (0),
        .HOLD_LDROM (4),
        .HOLD_RMOV  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .pmem_rd_en  (pmem_rd_en),
        .pmem_addr   (pmem_addr),
        .pmem_data   (pmem_data),
        .pmem_valid  (pmem_valid),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program memory: answers each strobe after lat cycles; a reset drops the request.
    initial begin
        int  a;
        bit  aborted;
        pmem_valid = 1'b0;
        pmem_data  = 8'h00;
        forever begin
            @(negedge clk);
            pmem_valid = 1'b0;
            if (rst !== 1'b1 && pmem_rd_en === 1'b1) begin
                a       = int'(pmem_addr);
                aborted = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (rst === 1'b1) aborted = 1'b1;
                end
                if (!aborted) begin
                    pmem_data  = mem[a];
                    pmem_valid = 1'b1;
                end
            end else if (spur_arm && instr_valid === 1'b1) begin
                pmem_data  = 8'hFF;
                pmem_valid = 1'b1;
                spur_arm   = 1'b0;
            end
        end
    end

    // Monitor: collapses each run of valid cycles into one issue record.
    initial begin
        bit         run;
        bit         seen;
        logic [7:0] cur;
        int         cnt;
        int         gap;
        int         rd_run;
        issue_t     t;
        run = 0; seen = 0; cur = 8'h00; cnt = 0; gap = 0; rd_run = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                run = 0; seen = 0; gap = 0; rd_run = 0;
            end else begin
                if (pmem_rd_en === 1'b1) begin
                    obs_addr_q.push_back(pmem_addr);
                    rd_run++;
                    if (rd_run > 1) rd_long_err++;
                end else begin
                    rd_run = 0;
                end
                if (instr_valid === 1'b1) begin
                    if (run && instruction !== cur) begin
                        t.instr = cur; t.cycles = cnt;
                        obs_q.push_back(t);
                        run = 0;
                    end
                    if (!run) begin
                        if (seen && gap < min_gap) min_gap = gap;
                        run = 1; seen = 1; cur = instruction; cnt = 0;
                    end
                    cnt++;
                    gap = 0;
                end else begin
                    if (run) begin
                        t.instr = cur; t.cycles = cnt;
                        obs_q.push_back(t);
                        run = 0;
                    end
                    if (instruction !== 8'h80) bubble_err++;
                    gap++;
                end
            end
        end
    end

    task automatic push_issue(input logic [7:0] instr, input int cycles);
        issue_t t;
        t.instr  = instr;
        t.cycles = cycles;
        exp_q.push_back(t);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        obs_q.delete();
        obs_addr_q.delete();
        bubble_err  = 0;
        rd_long_err = 0;
        min_gap     = 1000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        clear_mem();
        mem[0] = 8'h22;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) ok = 1'b1;
        end
        tests++;
        if (!ok) begin failed++; $display("[TB] FAIL reset_reach_issue: no issue within 20 cycles"); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (instruction !== 8'h80) begin failed++; $display("[TB] FAIL reset_instruction: got %h expected 80", instruction); end
        tests++; if (instr_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", instr_valid); end
        tests++; if (pmem_rd_en !== 1'b0) begin failed++; $display("[TB] FAIL reset_rd_en: got %b expected 0", pmem_rd_en); end
        tests++; if (halted !== 1'b0) begin failed++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
        tests++; if (pc !== 8'h00) begin failed++; $display("[TB] FAIL reset_pc: got %h expected 00", pc); end
        tests++; if (pmem_addr !== 8'h00) begin failed++; $display("[TB] FAIL reset_addr: got %h expected 00", pmem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit     ok;
        issue_t e, o;
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h22; mem[2] = 8'hE0;
        exp_q.delete(); exp_addr_q.delete();
        push_issue(8'h01, 1); push_issue(8'h22, 4); push_issue(8'hE0, 1);
        exp_addr_q.push_back(8'h00); exp_addr_q.push_back(8'h01); exp_addr_q.push_back(8'h02);
        do_reset();
        run_to_halt(100, ok);
        tests++; if (!ok) begin failed++; $display("[TB] FAIL basic_timeout: halted=%b expected 1", halted); end
        tests++; if (obs_q.size() != exp_q.size()) begin failed++; $display("[TB] FAIL basic_issue_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.instr !== e.instr || o.cycles != e.cycles) begin failed++; $display("[TB] FAIL basic_issue: got %h x%0d expected %h x%0d", o.instr, o.cycles, e.instr, e.cycles); end
        end
        tests++; if (obs_addr_q.size() != exp_addr_q.size()) begin failed++; $display("[TB] FAIL basic_addr_count: got %0d expected %0d", obs_addr_q.size(), exp_addr_q.size()); end
        while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
            logic [7:0] ea, oa;
            ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front();
            tests++; if (oa !== ea) begin failed++; $display("[TB] FAIL basic_addr: got %h expected %h", oa, ea); end
        end
        tests++; if (bubble_err != 0) begin failed++; $display("[TB] FAIL basic_bubble: got %0d non-bubble idle cycles expected 0", bubble_err); end
        tests++; if (min_gap != 2) begin failed++; $display("[TB] FAIL basic_gap: got %0d expected 2", min_gap); end
        tests++; if (rd_long_err != 0) begin failed++; $display("[TB] FAIL basic_rd_pulse: got %0d long strobes expected 0", rd_long_err); end
    endtask

    task automatic test_rmov_stall();
        bit     ok;
        issue_t e, o;
        clear_mem();
        mem[0] = 8'h45; mem[1] = 8'hE0;
        exp_q.delete();
        push_issue(8'h45, 3); push_issue(8'hE0, 1);
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) ok = 1'b1;
        end
        tests++; if (!ok) begin failed++; $display("[TB] FAIL rmov_timeout: no issue within 20 cycles"); end
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        stall = 1'b0;
        tests++; if (pc !== 8'h01) begin failed++; $display("[TB] FAIL rmov_pc: got %h expected 01", pc); end
        tests++; if (instruction !== 8'h45 || instr_valid !== 1'b1) begin failed++; $display("[TB] FAIL rmov_hold: got %h/%b expected 45/1", instruction, instr_valid); end
        run_to_halt(50, ok);
        tests++; if (!ok) begin failed++; $display("[TB] FAIL rmov_halt_timeout: halted=%b expected 1", halted); end
        tests++; if (obs_q.size() != exp_q.size()) begin failed++; $display("[TB] FAIL rmov_issue_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.instr !== e.instr || o.cycles != e.cycles) begin failed++; $display("[TB] FAIL rmov_issue: got %h x%0d expected %h x%0d", o.instr, o.cycles, e.instr, e.cycles); end
        end
    endtask

    task automatic test_pc_wrap();
        bit         ok;
        issue_t     e, o;
        logic [7:0] ea, oa;
        int         bad_issue;
        int         bad_addr;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        exp_q.delete(); exp_addr_q.delete();
        for (int i = 0; i < 256; i++) begin
            push_issue(8'h00, 1);
            exp_addr_q.push_back(8'(i));
        end
        push_issue(8'hE0, 1);
        exp_addr_q.push_back(8'h00);
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (pmem_rd_en === 1'b1 && pmem_addr === 8'hFF) ok = 1'b1;
        end
        tests++; if (!ok) begin failed++; $display("[TB] FAIL wrap_reach_ff: no fetch of address ff"); end
        mem[0] = 8'hE0;
        run_to_halt(50, ok);
        tests++; if (!ok) begin failed++; $display("[TB] FAIL wrap_halt_timeout: halted=%b expected 1", halted); end
        tests++; if (pc !== 8'h01) begin failed++; $display("[TB] FAIL wrap_pc: got %h expected 01", pc); end
        tests++; if (obs_addr_q.size() != exp_addr_q.size()) begin failed++; $display("[TB] FAIL wrap_addr_count: got %0d expected %0d", obs_addr_q.size(), exp_addr_q.size()); end
        bad_addr = 0;
        while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
            ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front();
            if (oa !== ea) bad_addr++;
        end
        tests++; if (bad_addr != 0) begin failed++; $display("[TB] FAIL wrap_addr: got %0d wrong addresses expected 0", bad_addr); end
        bad_issue = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.instr !== e.instr || o.cycles != e.cycles) bad_issue++;
        end
        tests++; if (bad_issue != 0) begin failed++; $display("[TB] FAIL wrap_issue: got %0d wrong issues expected 0", bad_issue); end
    endtask

    task automatic test_latency_spurious();
        bit     ok;
        issue_t e, o;
        clear_mem();
        mem[0] = 8'h22; mem[1] = 8'h45; mem[2] = 8'hE0;
        exp_q.delete();
        push_issue(8'h22, 4); push_issue(8'h45, 2); push_issue(8'hE0, 1);
        lat = 3;
        do_reset();
        spur_arm = 1'b1;
        run_to_halt(100, ok);
        lat = 1;
        spur_arm = 1'b0;
        tests++; if (!ok) begin failed++; $display("[TB] FAIL latency_timeout: halted=%b expected 1", halted); end
        tests++; if (obs_q.size() != exp_q.size()) begin failed++; $display("[TB] FAIL latency_issue_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.instr !== e.instr || o.cycles != e.cycles) begin failed++; $display("[TB] FAIL latency_issue: got %h x%0d expected %h x%0d", o.instr, o.cycles, e.instr, e.cycles); end
        end
        tests++; if (min_gap != 4) begin failed++; $display("[TB] FAIL latency_gap: got %0d expected 4", min_gap); end
    endtask

    task automatic test_halt();
        bit ok;
        int bad;
        clear_mem();
        do_reset();
        run_to_halt(50, ok);
        tests++; if (!ok) begin failed++; $display("[TB] FAIL halt_timeout: halted=%b expected 1", halted); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pmem_rd_en !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0 || instruction !== 8'h80) bad++;
        end
        tests++; if (bad != 0) begin failed++; $display("[TB] FAIL halt_idle: got %0d bad cycles expected 0", bad); end
        tests++; if (obs_q.size() != 1 || obs_q[0].instr !== 8'hE0 || obs_q[0].cycles != 1) begin failed++; $display("[TB] FAIL halt_issue: got %0d issues expected one E0 x1", obs_q.size()); end
        tests++; if (obs_addr_q.size() != 1) begin failed++; $display("[TB] FAIL halt_fetches: got %0d expected 1", obs_addr_q.size()); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (pc !== 8'h00 || halted !== 1'b0) begin failed++; $display("[TB] FAIL halt_reset: got pc=%h halted=%b expected 00/0", pc, halted); end
        ok = 1'b0;
        for (int i = 0; i < 5 && !ok; i++) begin
            @(negedge clk);
            if (pmem_rd_en === 1'b1) ok = 1'b1;
        end
        tests++; if (!ok || pmem_addr !== 8'h00) begin failed++; $display("[TB] FAIL halt_refetch: got strobe=%b addr=%h expected 1/00", ok, pmem_addr); end
    endtask

    task automatic test_jump();
        bit         ok;
        logic [7:0] ea, oa;
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'hD5;
        exp_addr_q.delete();
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(8'(i));
`ifdef FETCH_JUMP_EN
        exp_addr_q.push_back(8'h15);
`else
        exp_addr_q.push_back(8'h04);
`endif
        do_reset();
        run_to_halt(100, ok);
        tests++; if (!ok) begin failed++; $display("[TB] FAIL jump_timeout: halted=%b expected 1", halted); end
        tests++; if (obs_addr_q.size() != exp_addr_q.size()) begin failed++; $display("[TB] FAIL jump_addr_count: got %0d expected %0d", obs_addr_q.size(), exp_addr_q.size()); end
        while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
            ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front();
            tests++; if (oa !== ea) begin failed++; $display("[TB] FAIL jump_addr: got %h expected %h", oa, ea); end
        end
        tests++; if (obs_q.size() != 5 || obs_q[3].instr !== 8'hD5 || obs_q[3].cycles != 1) begin failed++; $display("[TB] FAIL jump_issue: got %0d issues expected 5 with D5 x1 fourth", obs_q.size()); end
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        lat         = 1;
        spur_arm    = 1'b0;
        rst         = 1'b1;
        stall       = 1'b0;
        bubble_err  = 0;
        rd_long_err = 0;
        min_gap     = 1000;
        clear_mem();
        do_reset();
        test_reset();
        test_basic();
        test_rmov_stall();
        test_pc_wrap();
        test_latency_spurious();
        test_halt();
        test_jump();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
